keypad_debounce: RTL
====================

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20, giving the number of consecutive stable cycles required to accept a press or a release; legal values are 2 or greater.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 key_val  input  8  scanner code {row_onehot[3:0], col_onehot[3:0]}; row bit 0 is the first scanned row, col bit 0 is column 0; all-zero means no key.
REQ-005 key_hex  output  4  hex value of the last accepted key.
REQ-006 key_pulse  output  1  one-cycle strobe on acceptance of a new press.
REQ-007 key_held  output  1  high in HELD and DEBOUNCE_RELEASE.
REQ-008 digit_right  output  4  most recently accepted digit.
REQ-009 digit_left  output  4  previously accepted digit.

Function
REQ-010 A code SHALL be valid only when exactly one bit of key_val[7:4] and exactly one bit of key_val[3:0] are set; any other non-zero code is invalid.
REQ-011 The decode (row,col) SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (col0..col3).
REQ-012 The FSM SHALL have the states IDLE, DEBOUNCE_PRESS, HELD and DEBOUNCE_RELEASE.
REQ-013 IDLE: on a valid code, capture key_val, clear the counter and go to DEBOUNCE_PRESS; zero or invalid codes leave the FSM in IDLE.
REQ-014 DEBOUNCE_PRESS: if key_val differs from the captured code, return to IDLE with no pulse; otherwise increment the counter.
REQ-015 DEBOUNCE_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 with a matching code, go to HELD.
REQ-016 On entry to HELD: key_pulse SHALL be high for exactly the next cycle; key_hex SHALL take the decoded value; digit_left SHALL take digit_right; digit_right SHALL take the decoded value.
REQ-017 Latency from the first cycle of a stable valid code to key_pulse SHALL be DEBOUNCE_CYCLES+1 cycles.
REQ-018 HELD: any non-zero key_val, including a different valid key, SHALL be ignored; a zero code SHALL clear the counter and go to DEBOUNCE_RELEASE.
REQ-019 DEBOUNCE_RELEASE: any non-zero code SHALL return the FSM to HELD without a pulse; DEBOUNCE_CYCLES consecutive zero cycles SHALL go to IDLE.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap; it is cleared on every state change.
REQ-021 Only one key_pulse SHALL be produced per press, however long the key is held.

Reset
REQ-022 Asserting reset SHALL force, at any time and mid-operation: state IDLE; counter 0; captured code 0; key_pulse 0; key_held 0; key_hex 0; digit_right 0; digit_left 0.
REQ-023 The first valid code after reset deassertion SHALL be handled as in IDLE, with no carry-over from the interrupted operation.

Structure
REQ-024 The state enum, the DEBOUNCE_CYCLES default and the 16-entry decode table SHALL reside in package keypad_pkg.
REQ-025 The decode SHALL be a combinational sub-module, keypad_decode (inputs: 8-bit code; outputs: 4-bit hex and a valid flag), instantiated once.

Verification
REQ-026 Hold key_val=8'b0001_0001 for 25 cycles (DEBOUNCE_CYCLES=20) -> key_pulse only in cycle 21; key_hex=4'h1; digit_right=1; digit_left=0.
REQ-027 key_val=8'b0010_0100 for 5 cycles, then 0, then stable for 25 cycles -> no pulse from the first burst; exactly one pulse; key_hex=4'h6.
REQ-028 Press 8'b1000_0010 (0), release for 30 cycles, press 8'b0100_1000 (C) -> pulses with values 0 then C; digit_left=0; digit_right=4'hC.
REQ-029 Press and hold 5 for 100 cycles, inserting single zero-cycle glitches and a switch to 8'b0001_0001 -> exactly one pulse; key_held stays 1; no second pulse.
REQ-030 key_val=8'b0011_0001 (invalid) for 50 cycles -> no pulse; FSM stays IDLE.
REQ-031 Assert reset during DEBOUNCE_PRESS and during HELD -> all outputs 0 immediately; a clean press afterwards produces the normal pulse at REQ-017 latency.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad debouncer.
// Holds the FSM state type, the default debounce length, the 16-entry
// (row, col) -> hex decode table and a small one-hot-to-index helper.
package keypad_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_IDLE             = 2'd0,
    ST_DEBOUNCE_PRESS   = 2'd1,
    ST_HELD             = 2'd2,
    ST_DEBOUNCE_RELEASE = 2'd3
  } kp_state_e;

  // Indexed by {row_index, col_index}.
  localparam logic [3:0] DECODE_TABLE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Position of the set bit of a one-hot nibble (caller checks one-hotness).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    onehot_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) onehot_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational scanner-code decoder.
// Ports:
//   code  in  8  {row_onehot[3:0], col_onehot[3:0]}
//   hex   out 4  decoded key value (0 when the code is not valid)
//   valid out 1  exactly one row bit and exactly one column bit are set
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] hex,
  output logic       valid
);

  logic [1:0] row_idx;
  logic [1:0] col_idx;

  always_comb begin
    valid   = $onehot(code[7:4]) && $onehot(code[3:0]);
    row_idx = onehot_index(code[7:4]);
    col_idx = onehot_index(code[3:0]);
    hex     = valid ? DECODE_TABLE[{row_idx, col_idx}] : 4'h0;
  end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad press/release debouncer with a two-digit history.
// A valid code must stay unchanged for DEBOUNCE_CYCLES+1 sampled cycles
// (the capture cycle plus DEBOUNCE_CYCLES matching cycles) to be accepted;
// a release needs one zero cycle in HELD followed by DEBOUNCE_CYCLES zero
// cycles in DEBOUNCE_RELEASE.
// Handshake: there is none; key_pulse is a single-cycle strobe, valid in the
// cycle during which key_hex/digit_right/digit_left already show the new key.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   key_val     in 8 scanner code, all-zero = no key
//   key_hex     out4 last accepted key
//   key_pulse   out1 one-cycle strobe per accepted press
//   key_held    out1 high in HELD and DEBOUNCE_RELEASE
//   digit_right out4 most recent accepted digit
//   digit_left  out4 previously accepted digit
//   fsm_state   out2 current FSM state (kp_state_e encoding), for debug
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_val,
  output logic [3:0] key_hex,
  output logic       key_pulse,
  output logic       key_held,
  output logic [3:0] digit_right,
  output logic [3:0] digit_left,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  kp_state_e     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    cap, cap_next;
  logic          accept;
  logic [3:0]    dec_hex;
  logic          dec_valid;

  keypad_decode u_decode (
    .code  (key_val),
    .hex   (dec_hex),
    .valid (dec_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cap   <= cap_next;
    end
  end

  // The counter is cleared on every state change and saturates at LAST
  // by construction: reaching LAST always forces a state change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap_next   = cap;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dec_valid) begin
          cap_next   = key_val;
          cnt_next   = '0;
          state_next = ST_DEBOUNCE_PRESS;
        end
      end
      ST_DEBOUNCE_PRESS: begin
        if (key_val != cap) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else if (cnt == LAST) begin
          cnt_next   = '0;
          accept     = 1'b1;
          state_next = ST_HELD;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ST_HELD: begin
        if (key_val == 8'h00) begin
          cnt_next   = '0;
          state_next = ST_DEBOUNCE_RELEASE;
        end
      end
      ST_DEBOUNCE_RELEASE: begin
        if (key_val != 8'h00) begin
          cnt_next   = '0;
          state_next = ST_HELD;
        end else if (cnt == LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // On acceptance key_val equals the captured code, so the live decode
  // is the captured key's value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_pulse   <= 1'b0;
      key_hex     <= 4'h0;
      digit_right <= 4'h0;
      digit_left  <= 4'h0;
    end else begin
      key_pulse <= accept;
      if (accept) begin
        key_hex     <= dec_hex;
        digit_left  <= digit_right;
        digit_right <= dec_hex;
      end
    end
  end

  assign key_held  = (state == ST_HELD) || (state == ST_DEBOUNCE_RELEASE);
  assign fsm_state = state;

endmodule
